// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding.
// Optional feature macro: FORWARDING_EN (undefined = no bypass, fwd sels tied 00).
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_reg_write,
  input  logic        id_alu_src,
  input  logic [31:0] id_imm,
  input  logic [3:0]  id_alu_opcode,
  input  logic [4:0]  ex_mem_rd_addr,
  input  logic        ex_mem_reg_write,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [4:0]  mem_wb_rd_addr,
  input  logic        mem_wb_reg_write,
  input  logic [31:0] mem_wb_data,
  output logic        ex_valid,
  output logic [31:0] ex_rs1,
  output logic [31:0] ex_rs2,
  output logic [3:0]  ex_alu_opcode,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd_addr,
  output logic        ex_reg_write,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel
);

  logic        r_valid;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic [4:0]  r_rd_addr;
  logic        r_reg_write;
  logic        r_alu_src;
  logic [31:0] r_imm;
  logic [3:0]  r_alu_opcode;

  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;
  logic [1:0]  w_sel_a;
  logic [1:0]  w_sel_b;

  // Pipeline register: reset > flush (bubble) > stall (hold) > load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_rs1_addr   <= '0;
      r_rs2_addr   <= '0;
      r_rd_addr    <= '0;
      r_reg_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_imm        <= '0;
      r_alu_opcode <= 4'b0000;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_rs1_addr   <= '0;
      r_rs2_addr   <= '0;
      r_rd_addr    <= '0;
      r_reg_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_imm        <= '0;
      r_alu_opcode <= 4'b0010;
    end else if (!stall) begin
      r_valid      <= id_valid;
      r_rs1_data   <= id_rs1_data;
      r_rs2_data   <= id_rs2_data;
      r_rs1_addr   <= id_rs1_addr;
      r_rs2_addr   <= id_rs2_addr;
      r_rd_addr    <= id_rd_addr;
      r_reg_write  <= id_reg_write & id_valid;
      r_alu_src    <= id_alu_src;
      r_imm        <= id_imm;
      r_alu_opcode <= id_alu_opcode;
    end
  end

`ifdef FORWARDING_EN
  logic w_a_exm;
  logic w_a_mwb;
  logic w_b_exm;
  logic w_b_mwb;

  // Hit detection; MEM/WB hit is masked by an EX/MEM hit (newer wins).
  always_comb begin
    w_a_exm = ex_mem_reg_write && (ex_mem_rd_addr != 5'd0)
              && (ex_mem_rd_addr == r_rs1_addr);
    w_b_exm = ex_mem_reg_write && (ex_mem_rd_addr != 5'd0)
              && (ex_mem_rd_addr == r_rs2_addr);
    w_a_mwb = !w_a_exm && mem_wb_reg_write
              && (mem_wb_rd_addr != 5'd0)
              && (mem_wb_rd_addr == r_rs1_addr);
    w_b_mwb = !w_b_exm && mem_wb_reg_write
              && (mem_wb_rd_addr != 5'd0)
              && (mem_wb_rd_addr == r_rs2_addr);
  end

  // Operand A bypass mux.
  always_comb begin
    w_fwd_a = r_rs1_data;
    w_sel_a = 2'b00;
    unique case (1'b1)
      w_a_exm: begin
        w_fwd_a = ex_mem_alu_result;
        w_sel_a = 2'b10;
      end
      w_a_mwb: begin
        w_fwd_a = mem_wb_data;
        w_sel_a = 2'b01;
      end
      default: ;
    endcase
  end

  // Operand B bypass mux.
  always_comb begin
    w_fwd_b = r_rs2_data;
    w_sel_b = 2'b00;
    unique case (1'b1)
      w_b_exm: begin
        w_fwd_b = ex_mem_alu_result;
        w_sel_b = 2'b10;
      end
      w_b_mwb: begin
        w_fwd_b = mem_wb_data;
        w_sel_b = 2'b01;
      end
      default: ;
    endcase
  end
`else
  logic w_unused_fwd;

  // No bypass: hazards are resolved upstream by stalling.
  always_comb begin
    w_fwd_a      = r_rs1_data;
    w_fwd_b      = r_rs2_data;
    w_sel_a      = 2'b00;
    w_sel_b      = 2'b00;
    w_unused_fwd = ^{ex_mem_rd_addr, ex_mem_reg_write,
                     ex_mem_alu_result, mem_wb_rd_addr,
                     mem_wb_reg_write, mem_wb_data,
                     r_rs1_addr, r_rs2_addr};
  end
`endif

  // EX-side outputs.
  always_comb begin
    ex_valid      = r_valid;
    ex_rs1        = w_fwd_a;
    ex_store_data = w_fwd_b;
    ex_rs2        = r_alu_src ? r_imm : w_fwd_b;
    ex_alu_opcode = r_alu_opcode;
    ex_rd_addr    = r_rd_addr;
    ex_reg_write  = r_reg_write;
    fwd_a_sel     = w_sel_a;
    fwd_b_sel     = w_sel_b;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic
// against a behavioural model of the ID/EX slot and bypass rules.
`timescale 1ns/1ps
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_reg_write, id_alu_src;
  logic [3:0]  id_alu_opcode;
  logic [4:0]  ex_mem_rd_addr, mem_wb_rd_addr;
  logic        ex_mem_reg_write, mem_wb_reg_write;
  logic [31:0] ex_mem_alu_result, mem_wb_data;
  logic        ex_valid, ex_reg_write;
  logic [31:0] ex_rs1, ex_rs2, ex_store_data;
  logic [3:0]  ex_alu_opcode;
  logic [4:0]  ex_rd_addr;
  logic [1:0]  fwd_a_sel, fwd_b_sel;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_alu_src(id_alu_src), .id_imm(id_imm),
    .id_alu_opcode(id_alu_opcode),
    .ex_mem_rd_addr(ex_mem_rd_addr),
    .ex_mem_reg_write(ex_mem_reg_write),
    .ex_mem_alu_result(ex_mem_alu_result),
    .mem_wb_rd_addr(mem_wb_rd_addr),
    .mem_wb_reg_write(mem_wb_reg_write),
    .mem_wb_data(mem_wb_data),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_alu_opcode(ex_alu_opcode), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  // Packed view of all outputs: 1+32+32+4+32+5+1+2+2 = 111 bits.
  logic [110:0] act;
  assign act = {ex_valid, ex_rs1, ex_rs2, ex_alu_opcode,
                ex_store_data, ex_rd_addr, ex_reg_write,
                fwd_a_sel, fwd_b_sel};

  // Model of the captured instruction in the EX slot.
  typedef struct {
    bit        v;
    bit [31:0] d1, d2, imm;
    bit [4:0]  a1, a2, rd;
    bit        rw, src;
    bit [3:0]  op;
  } slot_t;
  slot_t m;

  // Value a source operand ends up with, plus which path supplied it.
  function automatic bit [33:0] pick(bit [4:0] a, bit [31:0] d);
    if (FWD && a != 0 && ex_mem_reg_write && ex_mem_rd_addr == a)
      return {ex_mem_alu_result, 2'b10};
    if (FWD && a != 0 && mem_wb_reg_write && mem_wb_rd_addr == a)
      return {mem_wb_data, 2'b01};
    return {d, 2'b00};
  endfunction

  function automatic bit [110:0] expv();
    bit [33:0] fa, fb;
    bit [31:0] opb;
    fa  = pick(m.a1, m.d1);
    fb  = pick(m.a2, m.d2);
    opb = m.src ? m.imm : fb[33:2];
    return {m.v, fa[33:2], opb, m.op, fb[33:2], m.rd, m.rw,
            fa[1:0], fb[1:0]};
  endfunction

  // One clock edge; the model follows the reset/flush/stall/load rules.
  task automatic tick();
    slot_t n;
    n = m;
    if (!rst_n) begin
      n = '{default: 0};
    end else if (flush) begin
      n = '{default: 0};
      n.op = 4'b0010;
    end else if (!stall) begin
      n.v = id_valid; n.d1 = id_rs1_data; n.d2 = id_rs2_data;
      n.a1 = id_rs1_addr; n.a2 = id_rs2_addr; n.rd = id_rd_addr;
      n.rw = id_reg_write && id_valid; n.src = id_alu_src;
      n.imm = id_imm; n.op = id_alu_opcode;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic set_id(bit v, bit [4:0] a1, bit [31:0] d1,
                        bit [4:0] a2, bit [31:0] d2, bit [4:0] rd,
                        bit rw, bit src, bit [31:0] imm, bit [3:0] op);
    id_valid = v; id_rs1_addr = a1; id_rs1_data = d1;
    id_rs2_addr = a2; id_rs2_data = d2; id_rd_addr = rd;
    id_reg_write = rw; id_alu_src = src; id_imm = imm;
    id_alu_opcode = op;
  endtask

  task automatic clr_fwd();
    ex_mem_rd_addr = 0; ex_mem_reg_write = 0; ex_mem_alu_result = 0;
    mem_wb_rd_addr = 0; mem_wb_reg_write = 0; mem_wb_data = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; flush = 0; clr_fwd();
    set_id(1, 1, 32'h5, 2, 32'h7, 3, 1, 0, 0, 4'b0010);
    tick(); tick();
    n_tests++;
    if (act !== 111'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", act);
    end
    rst_n = 1;
    tick();
    n_tests++;
    if ({ex_valid, ex_rs1, ex_rs2, ex_alu_opcode, ex_rd_addr}
        !== {1'b1, 32'd5, 32'd7, 4'b0010, 5'd3}) begin
      n_fail++;
      $display("FAIL reset_release got v=%b a=%h b=%h op=%b rd=%0d exp 1/5/7/0010/3",
               ex_valid, ex_rs1, ex_rs2, ex_alu_opcode, ex_rd_addr);
    end
  endtask

  task automatic test_exmem_fwd();
    set_id(1, 3, 32'h111, 5, 32'h222, 6, 1, 0, 0, 4'b0110);
    clr_fwd();
    tick();
    ex_mem_rd_addr = 3; ex_mem_reg_write = 1;
    ex_mem_alu_result = 32'h64;
    #1;
    n_tests++;
    if ({ex_rs1, fwd_a_sel}
        !== (FWD ? {32'h64, 2'b10} : {32'h111, 2'b00})) begin
      n_fail++;
      $display("FAIL exmem_fwd got a=%h sel=%b fwd_en=%0d",
               ex_rs1, fwd_a_sel, FWD);
    end
    mem_wb_rd_addr = 3; mem_wb_reg_write = 1; mem_wb_data = 32'h99;
    #1;
    n_tests++;
    if ({ex_rs1, fwd_a_sel}
        !== (FWD ? {32'h64, 2'b10} : {32'h111, 2'b00})) begin
      n_fail++;
      $display("FAIL exmem_priority got a=%h sel=%b fwd_en=%0d",
               ex_rs1, fwd_a_sel, FWD);
    end
  endtask

  task automatic test_memwb_x0();
    set_id(1, 0, 32'h0, 4, 32'h44, 7, 1, 0, 0, 4'b0000);
    clr_fwd();
    tick();
    mem_wb_rd_addr = 4; mem_wb_reg_write = 1; mem_wb_data = 32'hAB;
    ex_mem_rd_addr = 0; ex_mem_reg_write = 1;
    ex_mem_alu_result = 32'hDEAD;
    #1;
    n_tests++;
    if ({ex_rs2, ex_store_data, fwd_b_sel} !== (FWD
        ? {32'hAB, 32'hAB, 2'b01} : {32'h44, 32'h44, 2'b00})) begin
      n_fail++;
      $display("FAIL memwb_fwd got b=%h sd=%h sel=%b fwd_en=%0d",
               ex_rs2, ex_store_data, fwd_b_sel, FWD);
    end
    n_tests++;
    if ({ex_rs1, fwd_a_sel} !== {32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL x0_no_fwd got a=%h sel=%b exp 0/00",
               ex_rs1, fwd_a_sel);
    end
  endtask

  task automatic test_imm();
    set_id(1, 1, 32'h1, 2, 32'h22, 9, 1, 1, 32'hFFFF_FFF0, 4'b0001);
    clr_fwd();
    tick();
    ex_mem_rd_addr = 2; ex_mem_reg_write = 1;
    ex_mem_alu_result = 32'h11;
    #1;
    n_tests++;
    if ({ex_rs2, ex_store_data, fwd_b_sel} !== (FWD
        ? {32'hFFFF_FFF0, 32'h11, 2'b10}
        : {32'hFFFF_FFF0, 32'h22, 2'b00})) begin
      n_fail++;
      $display("FAIL imm_operand got b=%h sd=%h sel=%b fwd_en=%0d",
               ex_rs2, ex_store_data, fwd_b_sel, FWD);
    end
  endtask

  task automatic test_stall_flush();
    logic [110:0] held;
    clr_fwd();
    set_id(1, 8, 32'hCAFE, 9, 32'hBEEF, 10, 1, 0, 0, 4'b0111);
    tick();
    held = act;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'($urandom), $urandom, 5'($urandom), $urandom,
             5'($urandom), 1, 1'($urandom), $urandom, 4'($urandom));
      tick();
      n_tests++;
      if (act !== held) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, act, held);
      end
    end
    flush = 1;
    tick();
    n_tests++;
    if ({ex_valid, ex_reg_write, ex_alu_opcode, ex_rs1, ex_rs2,
         ex_rd_addr} !== {1'b0, 1'b0, 4'b0010, 64'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL flush_over_stall got v=%b rw=%b op=%b a=%h b=%h rd=%0d",
               ex_valid, ex_reg_write, ex_alu_opcode, ex_rs1, ex_rs2,
               ex_rd_addr);
    end
    flush = 0;
    rst_n = 0;
    set_id(1, 1, 32'h9, 2, 32'h9, 3, 1, 0, 0, 4'b0001);
    tick();
    n_tests++;
    if (act !== 111'd0) begin
      n_fail++;
      $display("FAIL reset_mid_stall got=%h exp=0", act);
    end
    rst_n = 1; stall = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      set_id(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
             5'($urandom_range(0, 3)), $urandom,
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             $urandom, 4'($urandom));
      tick();
      ex_mem_rd_addr = 5'($urandom_range(0, 3));
      ex_mem_reg_write = 1'($urandom);
      ex_mem_alu_result = $urandom;
      mem_wb_rd_addr = 5'($urandom_range(0, 3));
      mem_wb_reg_write = 1'($urandom);
      mem_wb_data = $urandom;
      #1;
      n_tests++;
      if (act !== expv()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, act, expv());
      end
    end
  endtask

  initial begin
    m = '{default: 0};
    test_reset();
    test_exmem_fwd();
    test_memwb_x0();
    test_imm();
    test_stall_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
